output_trace_buffer: RTL and testbench

OUTPUT_TRACE_BUFFER -- requirements
Module: output_trace_buffer

---
 rtl/output_trace_buffer_if.sv | 31 +++
 rtl/output_trace_buffer.sv | 73 +++++++
 tb/tb_output_trace_buffer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/output_trace_buffer_if.sv
// Bus bundle for output_trace_buffer.
//   master : store-capture producer + record consumer (drives wr_*, out_ready)
//   slave  : the trace buffer (drives out_valid, out_record, count, full, drop_cnt)
// Parameters must match those given to the buffer instance.
interface output_trace_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [ADDR_W+DATA_W-1:0] out_record;
  logic [CW-1:0]            count;
  logic                     full;
  logic [15:0]              drop_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, out_ready,
    input  out_valid, out_record, count, full, drop_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, out_ready,
    output out_valid, out_record, count, full, drop_cnt
  );
endinterface

// File: rtl/output_trace_buffer.sv
// output_trace_buffer: captures processor data-memory stores as {addr, data}
// records into a first-word-fall-through FIFO for an external consumer.
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : output_trace_buffer_if.slave
//                wr_en/wr_addr/wr_data  store snoop
//                out_ready/out_valid/out_record  head-record handshake
//                count/full/drop_cnt  occupancy and overflow statistics
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
module output_trace_buffer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 16,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output_trace_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [15:0]   drops;

  logic capture, pop, is_full, valid, do_write, drop;

  // Zero address or zero data are treated as uninteresting stores.
  assign capture  = bus.wr_en &&
                    (!FILTER_ZERO || ((bus.wr_addr != '0) && (bus.wr_data != '0)));
  assign valid    = (cnt != '0);
  assign is_full  = (cnt == FULL_CNT);
  assign pop      = valid && bus.out_ready;
  // A pop frees the head slot in the same edge, so a full buffer can still
  // accept a capture when the consumer is taking a record.
  assign do_write = capture && (!is_full || pop);
  assign drop     = capture && is_full && !pop;

  // Storage carries no reset; stale slots are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && do_write)
      mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      drops  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop && (drops != 16'hFFFF))
        drops <= drops + 16'd1;
    end
  end

  assign bus.out_valid  = valid;
  assign bus.out_record = valid ? mem[rd_ptr] : '0;
  assign bus.count      = cnt;
  assign bus.full       = is_full;
  assign bus.drop_cnt   = drops;
endmodule

// File: tb/tb_output_trace_buffer.sv
module tb_output_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_trace_buffer_if #(.ADDR_W(16), .DATA_W(24), .DEPTH(16)) b1 ();
  output_trace_buffer_if #(.ADDR_W(16), .DATA_W(24), .DEPTH(16)) b0 ();

  output_trace_buffer #(.ADDR_W(16), .DATA_W(24), .DEPTH(16), .FILTER_ZERO(1'b1))
    u_f1 (.clk(clk), .reset(reset), .bus(b1));
  output_trace_buffer #(.ADDR_W(16), .DATA_W(24), .DEPTH(16), .FILTER_ZERO(1'b0))
    u_f0 (.clk(clk), .reset(reset), .bus(b0));

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [23:0] d;
    logic        rdy;
    logic        v;
    logic [39:0] rec;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic we, input logic [15:0] a, input logic [23:0] d, input logic rdy);
    b1.wr_en = we; b1.wr_addr = a; b1.wr_data = d; b1.out_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive1(1'b0, 16'h0, 24'h0, 1'b0);
    b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0; b0.out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 64'(b1.out_valid), 64'd0);
    chk({tag, " record"}, 64'(b1.out_record), 64'd0);
    chk({tag, " count"}, 64'(b1.count), 64'd0);
    chk({tag, " full"}, 64'(b1.full), 64'd0);
    chk({tag, " drop"}, 64'(b1.drop_cnt), 64'd0);
  endtask

  initial begin
    logic [39:0] x_rec;
    logic [39:0] exp_rec;

    tbl[0]  = '{1'b1, 16'h0010, 24'h0000AB, 1'b0, 1'b1, 40'h00100000AB, 5'd1};
    tbl[1]  = '{1'b1, 16'h0000, 24'h000005, 1'b0, 1'b1, 40'h00100000AB, 5'd1};
    tbl[2]  = '{1'b1, 16'h0003, 24'h000000, 1'b0, 1'b1, 40'h00100000AB, 5'd1};
    tbl[3]  = '{1'b0, 16'h0000, 24'h000000, 1'b0, 1'b1, 40'h00100000AB, 5'd1};
    tbl[4]  = '{1'b1, 16'h0020, 24'h0000CD, 1'b1, 1'b1, 40'h00200000CD, 5'd1};
    tbl[5]  = '{1'b0, 16'h0000, 24'h000000, 1'b1, 1'b0, 40'h0,          5'd0};
    tbl[6]  = '{1'b0, 16'h0000, 24'h000000, 1'b1, 1'b0, 40'h0,          5'd0};
    tbl[7]  = '{1'b1, 16'h0030, 24'h000001, 1'b1, 1'b1, 40'h0030000001, 5'd1};
    tbl[8]  = '{1'b1, 16'h0040, 24'h000002, 1'b0, 1'b1, 40'h0030000001, 5'd2};
    tbl[9]  = '{1'b0, 16'h0000, 24'h000000, 1'b1, 1'b1, 40'h0040000002, 5'd1};
    tbl[10] = '{1'b0, 16'h0000, 24'h000000, 1'b1, 1'b0, 40'h0,          5'd0};

    // Reset state
    do_reset();
    chk_idle("reset");

    // Table: basic capture, filtering, FWFT, stall, simultaneous push/pop
    for (int i = 0; i < 11; i++) begin
      drive1(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rdy);
      step();
      chk($sformatf("vec%0d valid", i), 64'(b1.out_valid), 64'(tbl[i].v));
      chk($sformatf("vec%0d record", i), 64'(b1.out_record), 64'(tbl[i].rec));
      chk($sformatf("vec%0d count", i), 64'(b1.count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d drop", i), 64'(b1.drop_cnt), 64'd0);
    end
    drive1(1'b0, 16'h0, 24'h0, 1'b0);

    // Unfiltered instance keeps zero-address / zero-data stores
    b0.wr_en = 1'b1; b0.wr_addr = 16'h0000; b0.wr_data = 24'h000005; step();
    b0.wr_addr = 16'h0003; b0.wr_data = 24'h000000; step();
    b0.wr_en = 1'b0;
    chk("nofilt count", 64'(b0.count), 64'd2);
    chk("nofilt head", 64'(b0.out_record), 64'h0000000005);
    b0.out_ready = 1'b1; step();
    chk("nofilt second", 64'(b0.out_record), 64'h0003000000);
    step();
    b0.out_ready = 1'b0;
    chk("nofilt empty", 64'(b0.count), 64'd0);

    // Overflow: 17 captures with no consumer
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive1(1'b1, 16'h0100 + 16'(i), 24'h000100 + 24'(i), 1'b0);
      step();
      if (i == 15) begin
        chk("fill16 full", 64'(b1.full), 64'd1);
        chk("fill16 drop", 64'(b1.drop_cnt), 64'd0);
      end
    end
    chk("ovf count", 64'(b1.count), 64'd16);
    chk("ovf full", 64'(b1.full), 64'd1);
    chk("ovf drop", 64'(b1.drop_cnt), 64'd1);
    chk("ovf head", 64'(b1.out_record), 64'h0100000100);

    // Full with capture and pop in the same cycle
    x_rec = 40'hBEEF00CAFE;
    drive1(1'b1, x_rec[39:24], x_rec[23:0], 1'b1);
    step();
    chk("fullpp count", 64'(b1.count), 64'd16);
    chk("fullpp drop", 64'(b1.drop_cnt), 64'd1);

    // Drain: records 1..15 then the full-cycle capture; record 16 was dropped
    drive1(1'b0, 16'h0, 24'h0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      exp_rec = (i == 16) ? x_rec : {16'h0100 + 16'(i), 24'h000100 + 24'(i)};
      chk($sformatf("drain%0d", i), 64'(b1.out_record), 64'(exp_rec));
      step();
    end
    chk("drain empty", 64'(b1.out_valid), 64'd0);
    chk("drain drop", 64'(b1.drop_cnt), 64'd1);

    // Streaming across three pointer wraps
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      drive1(1'b1, 16'(k), 24'(k), 1'b1);
      step();
      chk($sformatf("stream%0d rec", k), 64'(b1.out_record), 64'({16'(k), 24'(k)}));
      chk($sformatf("stream%0d cnt", k), 64'(b1.count), 64'd1);
    end
    drive1(1'b0, 16'h0, 24'h0, 1'b1);
    step();
    chk("stream end", 64'(b1.count), 64'd0);

    // Reset mid-operation; capture/pop during the reset cycle are discarded
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, 16'h0200 + 16'(i), 24'h000200 + 24'(i), 1'b0);
      step();
    end
    chk("hold5 count", 64'(b1.count), 64'd5);
    reset = 1'b1;
    drive1(1'b1, 16'h0777, 24'h000777, 1'b1);
    step();
    reset = 1'b0;
    drive1(1'b0, 16'h0, 24'h0, 1'b0);
    chk_idle("midreset");

    // First capture right after reset release
    drive1(1'b1, 16'h0055, 24'h000066, 1'b0);
    step();
    drive1(1'b0, 16'h0, 24'h0, 1'b0);
    chk("postrst count", 64'(b1.count), 64'd1);
    chk("postrst rec", 64'(b1.out_record), 64'h0055000066);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
